// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: scanout reads always win, processor writes queue in a FIFO
// and drain in idle slots. Define FB_CLEAR_EN to add the framebuffer clear engine.
module vga_fb_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int FB_PIXELS  = 307200
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cpu_wr_req,
    input  logic [ADDR_W-1:0]           cpu_wr_addr,
    input  logic [DATA_W-1:0]           cpu_wr_data,
    output logic                        cpu_wr_ready,
    input  logic                        vga_rd_req,
    input  logic [ADDR_W-1:0]           vga_rd_addr,
    output logic [DATA_W-1:0]           vga_rd_data,
    output logic                        vga_rd_valid,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    input  logic [DATA_W-1:0]           mem_rdata,
`ifdef FB_CLEAR_EN
    input  logic                        clear_start,
    input  logic [DATA_W-1:0]           clear_value,
    output logic                        clear_busy,
`endif
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 wr_stall_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0] SLOT_IDLE  = 2'd0;
    localparam logic [1:0] SLOT_READ  = 2'd1;
    localparam logic [1:0] SLOT_WRITE = 2'd2;
    localparam logic [1:0] SLOT_CLEAR = 2'd3;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              push, pop;
    logic [1:0]        slot;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              rd_pend_q, rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [15:0]       stall_q, stall_d;

`ifdef FB_CLEAR_EN
    // state    | meaning
    // CLR_IDLE | no clear in progress, FIFO drains normally
    // CLR_RUN  | writing clr_val_q to every pixel, FIFO held
    localparam logic [0:0] CLR_IDLE = 1'b0;
    localparam logic [0:0] CLR_RUN  = 1'b1;

    logic [0:0]        clr_state_q, clr_state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] clr_val_q, clr_val_d;
`endif

    always_comb begin
        slot = SLOT_IDLE;
        if (vga_rd_req)
            slot = SLOT_READ;
`ifdef FB_CLEAR_EN
        else if (clr_state_q == CLR_RUN)
            slot = SLOT_CLEAR;
`endif
        else if (level_q != '0)
            slot = SLOT_WRITE;
    end

    // Full blocks a push even when a pop frees an entry in the same cycle.
    assign push    = cpu_wr_req && (level_q != LVL_W'(FIFO_DEPTH));
    assign pop     = (slot == SLOT_WRITE);
    assign level_d = level_q + LVL_W'(push) - LVL_W'(pop);

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        case (slot)
            SLOT_READ: mem_addr_d = vga_rd_addr;
            SLOT_WRITE: begin
                mem_addr_d  = fifo_addr_q[rd_ptr_q];
                mem_wdata_d = fifo_data_q[rd_ptr_q];
                mem_we_d    = 1'b1;
            end
`ifdef FB_CLEAR_EN
            SLOT_CLEAR: begin
                mem_addr_d  = clr_cnt_q;
                mem_wdata_d = clr_val_q;
                mem_we_d    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (level_q != '0 && (slot == SLOT_READ || slot == SLOT_CLEAR) && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= cpu_wr_addr;
            fifo_data_q[wr_ptr_q] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            stall_q     <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q     <= level_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rd_pend_q   <= vga_rd_req;
            rd_valid_q  <= rd_pend_q;
            // RAM returns data the cycle after it sees the registered read address.
            if (rd_pend_q) rd_data_q <= mem_rdata;
            stall_q     <= stall_d;
        end
    end

`ifdef FB_CLEAR_EN
    always_comb begin
        clr_state_d = clr_state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_val_d   = clr_val_q;
        case (clr_state_q)
            CLR_IDLE: begin
                if (clear_start) begin
                    clr_state_d = CLR_RUN;
                    clr_cnt_d   = '0;
                    clr_val_d   = clear_value;
                end
            end
            default: begin
                if (slot == SLOT_CLEAR) begin
                    if (clr_cnt_q == ADDR_W'(FB_PIXELS - 1))
                        clr_state_d = CLR_IDLE;
                    else
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_state_q <= CLR_IDLE;
            clr_cnt_q   <= '0;
            clr_val_q   <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_val_q   <= clr_val_d;
        end
    end

    assign clear_busy = (clr_state_q == CLR_RUN);
`endif

    assign cpu_wr_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign fifo_level   = level_q;
    assign wr_stall_cnt = stall_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_we       = mem_we_q;
    assign vga_rd_valid = rd_valid_q;
    assign vga_rd_data  = rd_data_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: directed steps plus random traffic against a
// queue-based reference of the arbitration rules. Define FB_CLEAR_EN to exercise the clear engine.
module tb_vga_fb_arbiter;

    localparam int AW    = 19;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PIX   = 64;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_wr_req = 1'b0;
    logic [AW-1:0] cpu_wr_addr = '0;
    logic [DW-1:0] cpu_wr_data = '0;
    logic          cpu_wr_ready;
    logic          vga_rd_req = 1'b0;
    logic [AW-1:0] vga_rd_addr = '0;
    logic [DW-1:0] vga_rd_data;
    logic          vga_rd_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [3:0]    fifo_level;
    logic [15:0]   wr_stall_cnt;
    logic          clear_start = 1'b0;
    logic [DW-1:0] clear_value = '0;
`ifdef FB_CLEAR_EN
    logic          clear_busy;
`endif

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FB_PIXELS(PIX)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_wr_req   (cpu_wr_req),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ready (cpu_wr_ready),
        .vga_rd_req   (vga_rd_req),
        .vga_rd_addr  (vga_rd_addr),
        .vga_rd_data  (vga_rd_data),
        .vga_rd_valid (vga_rd_valid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
`ifdef FB_CLEAR_EN
        .clear_start  (clear_start),
        .clear_value  (clear_value),
        .clear_busy   (clear_busy),
`endif
        .fifo_level   (fifo_level),
        .wr_stall_cnt (wr_stall_cnt)
    );

    always #5 clock = ~clock;

    // The arbiter registers address/we, so the array read here is the synchronous RAM output.
    bit [7:0] ram     [0:(1<<AW)-1];
    bit [7:0] ref_mem [0:(1<<AW)-1];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clock) if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { int due; logic [DW-1:0] d; } rd_t;
    wr_t q[$];
    rd_t rq[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc_n    = 0;
    logic [15:0]   m_stall;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    bit            m_busy;
    int            m_cnt;
    logic [DW-1:0] m_cval;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rq.delete();
        m_stall = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_busy  = 1'b0;
        m_cnt   = 0;
        m_cval  = '0;
    endtask

    task automatic cyc();
        bit  do_rd, do_clr, do_wr, push_ok, busy_old, exp_v;
        wr_t e;
        rd_t r;
        chk("cpu_wr_ready", cpu_wr_ready, q.size() != DEPTH);
        chk("fifo_level", fifo_level, q.size());
        chk("wr_stall_cnt", wr_stall_cnt, m_stall);
`ifdef FB_CLEAR_EN
        chk("clear_busy", clear_busy, m_busy);
`endif
        busy_old = m_busy;
        push_ok  = cpu_wr_req && (q.size() != DEPTH);
        do_rd    = vga_rd_req;
        do_clr   = !do_rd && m_busy;
        do_wr    = !do_rd && !do_clr && (q.size() != 0);
        if (q.size() != 0 && (do_rd || do_clr) && m_stall != 16'hFFFF) m_stall++;
        if (do_rd) begin
            m_addr = vga_rd_addr;
            r.due  = cyc_n + 2;
            r.d    = ref_mem[vga_rd_addr];
            rq.push_back(r);
        end
        if (do_clr) begin
            m_addr  = AW'(m_cnt);
            m_wdata = m_cval;
            ref_mem[m_cnt] = m_cval;
            if (m_cnt == PIX - 1) m_busy = 1'b0;
            else m_cnt++;
        end
        if (do_wr) begin
            e = q.pop_front();
            m_addr  = e.a;
            m_wdata = e.d;
            ref_mem[e.a] = e.d;
        end
        if (push_ok) begin
            e.a = cpu_wr_addr;
            e.d = cpu_wr_data;
            q.push_back(e);
        end
        if (clear_start && !busy_old) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_cval = clear_value;
        end
        @(posedge clock);
        #1;
        cyc_n++;
        chk("mem_we", mem_we, do_clr || do_wr);
        chk("mem_addr", mem_addr, m_addr);
        if (do_clr || do_wr) chk("mem_wdata", mem_wdata, m_wdata);
        exp_v = (rq.size() != 0) && (rq[0].due == cyc_n);
        if (exp_v) m_rdata = rq.pop_front().d;
        chk("vga_rd_valid", vga_rd_valid, exp_v);
        if (exp_v) chk("vga_rd_data", vga_rd_data, m_rdata);
    endtask

    task automatic tick(input bit rd, input logic [AW-1:0] ra, input bit wr,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        vga_rd_req  = rd;
        vga_rd_addr = ra;
        cpu_wr_req  = wr;
        cpu_wr_addr = wa;
        cpu_wr_data = wd;
        cyc();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", cpu_wr_ready, 1);
        chk("rst_level", fifo_level, 0);
        chk("rst_stall", wr_stall_cnt, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_valid", vga_rd_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", vga_rd_data, 0);
        reset = 1'b0;

        // single write drains into an idle RAM
        tick(0, '0, 1, 19'h00010, 8'hA5);
        tick(0, '0, 0, '0, '0);
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 19'h00010);
        chk("t1_wdata", mem_wdata, 8'hA5);
        chk("t1_level", fifo_level, 0);

        // read latency of two cycles
        ram[19'h12345]     = 8'h3C;
        ref_mem[19'h12345] = 8'h3C;
        tick(1, 19'h12345, 0, '0, '0);
        tick(0, '0, 0, '0, '0);
        chk("t2_valid", vga_rd_valid, 1);
        chk("t2_data", vga_rd_data, 8'h3C);
        tick(0, '0, 0, '0, '0);

        // reads starve the FIFO; ninth write is refused
        tick(0, '0, 1, 19'h00200, 8'h80);
        for (int i = 0; i < 20; i++) begin
            tick(1, AW'(19'h00300 + i), i < 8, AW'(19'h00201 + i), DW'(8'h81 + i));
            if (i == 6) chk("t3_full_ready", cpu_wr_ready, 0);
        end
        chk("t3_stall", wr_stall_cnt, 20);
        chk("t3_level", fifo_level, 8);
        for (int i = 0; i < 8; i++) tick(0, '0, 0, '0, '0);
        chk("t3_last_addr", mem_addr, 19'h00207);
        chk("t3_drained", fifo_level, 0);

        // push+pop at level 4 across pointer wrap
        for (int i = 0; i < 4; i++) tick(1, AW'(19'h00300 + i), 1, AW'(19'h00220 + i), DW'(8'h40 + i));
        chk("t4_level4", fifo_level, 4);
        for (int i = 4; i < 20; i++) begin
            tick(0, '0, 1, AW'(19'h00220 + i), DW'(8'h40 + i));
            chk("t4_level_hold", fifo_level, 4);
        end
        for (int i = 0; i < 6; i++) tick(0, '0, 0, '0, '0);

        // random traffic over a small window so reads and writes collide
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 1) == 1, AW'(19'h00100 + $urandom_range(0, 63)),
                 $urandom_range(0, 9) < 6, AW'(19'h00100 + $urandom_range(0, 63)),
                 DW'($urandom));
        for (int i = 0; i < 12; i++) tick(0, '0, 0, '0, '0);

        // reset with queued writes and a read in flight
        for (int i = 0; i < 5; i++) tick(1, AW'(19'h00300 + i), 1, AW'(19'h7F000 + i), DW'(8'hC0 + i));
        reset = 1'b1;
        #1;
        chk("t5_level", fifo_level, 0);
        chk("t5_valid", vga_rd_valid, 0);
        chk("t5_we", mem_we, 0);
        chk("t5_stall", wr_stall_cnt, 0);
        model_reset();
        #2;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick(0, '0, 0, '0, '0);

`ifdef FB_CLEAR_EN
        clear_start = 1'b1;
        clear_value = 8'h07;
        tick(0, '0, 0, '0, '0);
        clear_start = 1'b0;
        clear_value = 8'h55;
        tick(0, '0, 1, 19'd3, 8'hFF);
        for (int i = 0; i < 120; i++) begin
            clear_start = (i == 10);
            tick((i % 5) == 2, AW'(i % 8), 0, '0, '0);
        end
        clear_start = 1'b0;
        chk("t6_busy_done", clear_busy, 0);
        chk("t6_ram3", ram[3], 8'hFF);
        chk("t6_ram0", ram[0], 8'h07);
        chk("t6_ram63", ram[63], 8'h07);
`endif

        for (int a = 0; a < 1024; a++) chk($sformatf("ram_%0h", a), ram[a], ref_mem[a]);
        for (int a = 19'h7F000; a < 19'h7F008; a++) chk($sformatf("ram_%0h", a), ram[a], ref_mem[a]);
        chk("ram_12345", ram[19'h12345], ref_mem[19'h12345]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
